sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Time-multiplexed driver for a common-anode, N-digit seven-segment display with per-digit decimal points. It accepts a packed hex value and per-digit masks through a load strobe, and presents them tear-free at frame boundaries. It scans one digit per slot and drives the active-low anode, segment and dot pins directly. Brightness is PWM-controlled and leading-zero suppression is optional. It sits between status/debug logic and the board display pins, replacing per-digit static decode.

## Interface
- NUM_DIGITS, 4: digits scanned, ≥1.
- SCAN_DIV, 100000: clock cycles per digit slot; must be a multiple of 16 and ≥16.
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- value  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is shown on digit i; digit 0 is rightmost.
- dp_mask  in  NUM_DIGITS  1 = dot on for digit i.
- blank_mask  in  NUM_DIGITS  1 = digit i fully dark (segments and dot).
- load  in  1  single-cycle strobe; captures value, dp_mask and blank_mask.
- lz_en  in  1  leading-zero suppression enable; used live, not latched.
- brightness  in  4  PWM level 0..15; used live.
- an  out  NUM_DIGITS  anode enables, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  dot, active-low.
- pending  out  1  a captured load is waiting for the next frame boundary.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

## Operation
- Registers:
  - Shadow set (value/dp/blank) written on load.
  - Display set used for rendering.
  - Slot counter cnt, 0..SCAN_DIV-1.
  - Digit index idx, 0..NUM_DIGITS-1.
- cnt increments every cycle. At cnt==SCAN_DIV-1, cnt wraps to 0 and idx advances. After NUM_DIGITS-1, idx wraps to 0.
- Frame boundary: the cycle where cnt==SCAN_DIV-1 and idx==NUM_DIGITS-1.
  - If pending=1: display set ← shadow set, and pending clears.
- load sets pending=1 and overwrites the shadow. Multiple loads within a frame: the last one wins.
- load in the frame-boundary cycle:
  - The old shadow transfers to the display set.
  - The new data enters the shadow.
  - pending stays 1.
- Decode: standard hex glyphs 0–F on active-low segments. Examples (seg[6:0]): 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
- Leading-zero suppression (lz_en=1): digit i>0 is suppressed if nibbles i..NUM_DIGITS-1 are all 0.
  - A suppressed digit drives seg=1111111 but dp still follows dp_mask.
  - Digit 0 is never suppressed.
- Blanking: blank_mask[i]=1 forces seg=1111111 and dp=1 for digit i. Blanking overrides everything.
- PWM: STEP=SCAN_DIV/16. The anode of digit idx is asserted when cnt < STEP*brightness.
  - brightness=0: display dark.
  - brightness=15: duty 15/16. The dark tail of each slot is the ghosting guard.
- Only one anode bit is ever low. When the anode is off, seg and dp are driven all-1.

## Timing
- Reset values (rst_n=0 at a clk edge):
  - an all-1, seg=1111111, dp=1, pending=0, frame_start=0.
  - cnt=0, idx=0.
  - Shadow and display sets all 0; blank masks 0.
- Outputs an, seg, dp and frame_start are registered: each is a function of (idx, cnt, display set, lz_en, brightness) from the previous cycle. Latency is 1 cycle.
- frame_start is high for one cycle, in the cycle after the counter reaches idx=0, cnt=0.
- Frame period is NUM_DIGITS*SCAN_DIV cycles.
- Load-to-display latency: at most one frame plus 1 cycle, at least 2 cycles.
- pending asserts in the cycle after load and deasserts in the cycle after the boundary transfer.
- Reset mid-frame returns to idx=0, cnt=0 with pending cleared. A captured but untransferred load is discarded.

## Test plan
Bench uses NUM_DIGITS=4, SCAN_DIV=32 (STEP=2).
- Reset then free-run, brightness=15, no load:
  - an cycles 1110→1101→1011→0111, every 32 cycles, each active for 30 of 32 cycles.
  - seg=1000000 throughout; frame_start every 128 cycles.
- load value=16'h12AF mid-frame:
  - Display unchanged until the boundary; pending=1 until then.
  - After the boundary: digit0 seg=0001110, digit1=0001000, digit2=0100100, digit3=1111001.
- value=16'h0005, lz_en=1, dp_mask=4'b0100:
  - Digits 3 and 2 have seg=1111111; digit 2 has dp=0.
  - Digit 1 is dark; digit 0 seg=0010010.
  - With lz_en=0, digits 3..1 show 1000000.
- brightness=4:
  - Each anode is low for cycles 0..7 of its slot.
- brightness=0 and blank_mask=4'b0001 with brightness=15:
  - brightness=0: an stays 1111.
  - blank_mask=4'b0001: digit 0 is fully dark while the other digits display.
- load asserted exactly at the boundary cycle, then rst_n pulsed mid-next-frame:
  - The prior shadow is displayed and pending stays 1.
  - After reset: all outputs at their reset values and pending=0.

Source files
------------

// File: rtl/sevenseg_scan.sv
// Multiplexed common-anode seven-segment driver with PWM brightness, optional
// leading-zero suppression and tear-free double-buffered loads.
module sevenseg_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    pending,
    output logic                    frame_start
);

    localparam int CW   = $clog2(SCAN_DIV);
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int STEP = SCAN_DIV / 16;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_value, disp_value;
    logic [NUM_DIGITS-1:0]   shadow_dp, disp_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank, disp_blank;

    logic                    slot_end, last_digit, boundary;
    logic [3:0]              nib;
    logic                    above_zero, dp_bit, blank_bit, suppress, lit;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              seg_d;
    logic                    dp_d;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    assign slot_end   = (cnt == CW'(SCAN_DIV - 1));
    assign last_digit = (idx == IW'(NUM_DIGITS - 1));
    assign boundary   = slot_end && last_digit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= last_digit ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // A load coinciding with the boundary still moves the older shadow out
    // first, so pending must stay set for the newly captured data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            disp_value   <= '0;
            disp_dp      <= '0;
            disp_blank   <= '0;
            pending      <= 1'b0;
        end else begin
            if (boundary && pending) begin
                disp_value <= shadow_value;
                disp_dp    <= shadow_dp;
                disp_blank <= shadow_blank;
            end
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp_mask;
                shadow_blank <= blank_mask;
                pending      <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        nib        = '0;
        dp_bit     = 1'b0;
        blank_bit  = 1'b0;
        above_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx) begin
                nib       = disp_value[4*i +: 4];
                dp_bit    = disp_dp[i];
                blank_bit = disp_blank[i];
            end
            if (i >= int'(idx) && disp_value[4*i +: 4] != 4'h0) begin
                above_zero = 1'b0;
            end
        end
        suppress = lz_en && (idx != '0) && above_zero;
        lit      = (32'(cnt) < 32'(STEP) * 32'(brightness));

        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (lit) begin
            an_d[idx] = 1'b0;
            if (!blank_bit) begin
                seg_d = suppress ? 7'h7F : decode(nib);
                dp_d  = ~dp_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= (idx == '0) && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan: a frame-position model derived from the
// display rules predicts every pin each cycle, plus directed glyph/duty checks.
module tb_sevenseg_scan;

    localparam int N     = 4;
    localparam int SD    = 32;
    localparam int STEP  = SD / 16;
    localparam int FRAME = N * SD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   value;
    logic [3:0]    dp_mask, blank_mask, brightness;
    logic          load, lz_en;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp, pending, frame_start;

    always #5 clk = ~clk;

    sevenseg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .load(load), .lz_en(lz_en),
        .brightness(brightness), .an(an), .seg(seg), .dp(dp),
        .pending(pending), .frame_start(frame_start)
    );

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks = 0;
    int errors = 0;

    // Model: frame position plus shadow/display sets, advanced once per clock edge.
    int          m_pos;
    logic        m_pend;
    logic [15:0] m_sv, m_dv;
    logic [3:0]  m_sd, m_sb, m_dd, m_db;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;

    task automatic step();
        int d, c;
        logic [15:0] up;
        @(posedge clk);
        if (!rst_n) begin
            m_pos = 0; m_pend = 1'b0;
            m_sv = '0; m_sd = '0; m_sb = '0; m_dv = '0; m_dd = '0; m_db = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            d  = m_pos / SD;
            c  = m_pos % SD;
            up = m_dv >> (4 * d);
            e_fs = (m_pos == 0);
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            if (c < STEP * int'(brightness)) begin
                e_an = ~(4'b0001 << d);
                if (!m_db[d]) begin
                    e_seg = (lz_en && d > 0 && up == 16'h0) ? 7'h7F : glyph[up[3:0]];
                    e_dp  = ~m_dd[d];
                end
            end
            if (m_pos == FRAME - 1 && m_pend) begin
                m_dv = m_sv; m_dd = m_sd; m_db = m_sb; m_pend = 1'b0;
            end
            if (load) begin
                m_sv = value; m_sd = dp_mask; m_sb = blank_mask; m_pend = 1'b1;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; value = '0; dp_mask = '0; blank_mask = '0;
        lz_en = 1'b0; brightness = 4'd15;
        step(); step();
        checks++; if (an !== 4'hF) begin errors++; $display("[TB] FAIL reset_an got %b expected 1111", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("[TB] FAIL reset_seg got %b expected 1111111", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp got %b expected 1", dp); end
        checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending got %b expected 0", pending); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_fs got %b expected 0", frame_start); end
    endtask

    task automatic test_free_run();
        int fs_cnt = 0, an0_cnt = 0;
        rst_n = 1'b1;
        for (int t = 0; t < 2 * FRAME; t++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_start, pending} !== {e_an, e_seg, e_dp, e_fs, m_pend}) begin
                errors++;
                $display("[TB] FAIL free_run t=%0d got %b expected %b", t,
                         {an, seg, dp, frame_start, pending}, {e_an, e_seg, e_dp, e_fs, m_pend});
            end
            if (frame_start) fs_cnt++;
            if (an == 4'b1110) an0_cnt++;
        end
        checks++; if (fs_cnt != 2) begin errors++; $display("[TB] FAIL frame_start_count got %0d expected 2", fs_cnt); end
        checks++; if (an0_cnt != 60) begin errors++; $display("[TB] FAIL digit0_duty got %0d expected 60", an0_cnt); end
    endtask

    task automatic test_load();
        logic [6:0] exp_g [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
        for (int t = 0; t < 40; t++) step();
        value = 16'h12AF; load = 1'b1;
        step();
        load = 1'b0; value = $urandom();
        checks++; if (pending !== 1'b1) begin errors++; $display("[TB] FAIL load_pending got %b expected 1", pending); end
        for (int t = 0; t < FRAME + 2 && m_pos != 0; t++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_start, pending} !== {e_an, e_seg, e_dp, e_fs, m_pend}) begin
                errors++;
                $display("[TB] FAIL load_hold t=%0d got %b expected %b", t,
                         {an, seg, dp, frame_start, pending}, {e_an, e_seg, e_dp, e_fs, m_pend});
            end
        end
        for (int t = 0; t < FRAME; t++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_start, pending} !== {e_an, e_seg, e_dp, e_fs, m_pend}) begin
                errors++;
                $display("[TB] FAIL load_show t=%0d got %b expected %b", t,
                         {an, seg, dp, frame_start, pending}, {e_an, e_seg, e_dp, e_fs, m_pend});
            end
            for (int d = 0; d < N; d++) begin
                if (an == ~(4'b0001 << d)) begin
                    checks++;
                    if (seg !== exp_g[d]) begin
                        errors++;
                        $display("[TB] FAIL glyph_12AF digit %0d got %b expected %b", d, seg, exp_g[d]);
                    end
                end
            end
        end
    endtask

    task automatic test_lz();
        value = 16'h0005; dp_mask = 4'b0100; blank_mask = '0; lz_en = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        for (int t = 0; t < FRAME + 2 && m_pos != 0; t++) step();
        for (int pass = 0; pass < 2; pass++) begin
            lz_en = (pass == 0);
            for (int t = 0; t < FRAME; t++) begin
                step();
                checks++;
                if ({an, seg, dp, frame_start, pending} !== {e_an, e_seg, e_dp, e_fs, m_pend}) begin
                    errors++;
                    $display("[TB] FAIL lz pass=%0d t=%0d got %b expected %b", pass, t,
                             {an, seg, dp, frame_start, pending}, {e_an, e_seg, e_dp, e_fs, m_pend});
                end
                if (t > 0 && an == 4'b1011) begin
                    checks++;
                    if ({seg, dp} !== {(pass == 0) ? 7'h7F : 7'h40, 1'b0}) begin
                        errors++;
                        $display("[TB] FAIL lz_digit2 pass=%0d got seg=%b dp=%b", pass, seg, dp);
                    end
                end
                if (t > 0 && an == 4'b1110) begin
                    checks++;
                    if (seg !== 7'h12) begin errors++; $display("[TB] FAIL lz_digit0 got %b expected 0010010", seg); end
                end
            end
        end
    endtask

    task automatic test_brightness();
        int low_cnt = 0, lit_bad = 0;
        brightness = 4'd4;
        step();
        for (int t = 0; t < FRAME; t++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_start, pending} !== {e_an, e_seg, e_dp, e_fs, m_pend}) begin
                errors++;
                $display("[TB] FAIL bright4 t=%0d got %b expected %b", t,
                         {an, seg, dp, frame_start, pending}, {e_an, e_seg, e_dp, e_fs, m_pend});
            end
            if (an != 4'hF) low_cnt++;
        end
        checks++; if (low_cnt != 32) begin errors++; $display("[TB] FAIL bright4_duty got %0d expected 32", low_cnt); end
        brightness = 4'd0;
        step();
        for (int t = 0; t < FRAME; t++) begin
            step();
            if (an !== 4'hF || seg !== 7'h7F) lit_bad++;
        end
        checks++; if (lit_bad != 0) begin errors++; $display("[TB] FAIL bright0_dark got %0d lit cycles expected 0", lit_bad); end
    endtask

    task automatic test_blank();
        brightness = 4'd15; lz_en = 1'b0;
        value = 16'h1234; dp_mask = 4'b1111; blank_mask = 4'b0001; load = 1'b1;
        step();
        load = 1'b0;
        for (int t = 0; t < FRAME + 2 && m_pos != 0; t++) step();
        for (int t = 0; t < FRAME; t++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_start, pending} !== {e_an, e_seg, e_dp, e_fs, m_pend}) begin
                errors++;
                $display("[TB] FAIL blank t=%0d got %b expected %b", t,
                         {an, seg, dp, frame_start, pending}, {e_an, e_seg, e_dp, e_fs, m_pend});
            end
            if (t > 0 && an == 4'b1110 && {seg, dp} !== 8'hFF) begin
                errors++; checks++;
                $display("[TB] FAIL blank_digit0 got seg=%b dp=%b expected 1111111 1", seg, dp);
            end
            if (t > 0 && an == 4'b1101) begin
                checks++;
                if ({seg, dp} !== {7'h30, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL blank_digit1 got seg=%b dp=%b expected 0110000 0", seg, dp);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        value = 16'h0A0B; dp_mask = '0; blank_mask = '0; load = 1'b1;
        step();
        load = 1'b0;
        for (int t = 0; t < FRAME + 2 && m_pos != FRAME - 1; t++) step();
        checks++; if (m_pos != FRAME - 1) begin errors++; $display("[TB] FAIL boundary_reach got %0d expected %0d", m_pos, FRAME - 1); end
        value = 16'h5678; load = 1'b1;
        step();
        load = 1'b0;
        checks++; if (pending !== 1'b1) begin errors++; $display("[TB] FAIL boundary_pending got %b expected 1", pending); end
        for (int t = 0; t < 60; t++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_start, pending} !== {e_an, e_seg, e_dp, e_fs, m_pend}) begin
                errors++;
                $display("[TB] FAIL boundary_show t=%0d got %b expected %b", t,
                         {an, seg, dp, frame_start, pending}, {e_an, e_seg, e_dp, e_fs, m_pend});
            end
            if (an == 4'b1110 && seg !== 7'h03) begin
                errors++; checks++;
                $display("[TB] FAIL boundary_digit0 got %b expected 0000011", seg);
            end
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({an, seg, dp, frame_start, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midframe_reset got %b expected 11111111111100", {an, seg, dp, frame_start, pending});
        end
        rst_n = 1'b1;
        for (int t = 0; t < FRAME + 4; t++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_start, pending} !== {e_an, e_seg, e_dp, e_fs, m_pend}) begin
                errors++;
                $display("[TB] FAIL after_reset t=%0d got %b expected %b", t,
                         {an, seg, dp, frame_start, pending}, {e_an, e_seg, e_dp, e_fs, m_pend});
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 1200; t++) begin
            load = ($urandom_range(0, 29) == 0);
            value = $urandom();
            dp_mask = 4'($urandom());
            blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
            if ($urandom_range(0, 49) == 0) lz_en = 1'($urandom());
            if ($urandom_range(0, 49) == 0) brightness = 4'($urandom());
            step();
            checks++;
            if ({an, seg, dp, frame_start, pending} !== {e_an, e_seg, e_dp, e_fs, m_pend}) begin
                errors++;
                $display("[TB] FAIL random t=%0d got %b expected %b", t,
                         {an, seg, dp, frame_start, pending}, {e_an, e_seg, e_dp, e_fs, m_pend});
            end
        end
        load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_load();
        test_lz();
        test_brightness();
        test_blank();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
